// File: rtl/alu_seq_calc_pkg.sv
// Shared opcode and FSM definitions for the sequential ALU calculator.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER,
        S_DONE
    } state_t;

    // Multiply and divide run through the iterative unit; everything else is single-cycle.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_calc_mul_div_iter.sv
// Iterative unsigned unit: shift-add multiply and restoring divide, one step per clock.
module mul_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod_or_qr,
    output logic               dz
);

    localparam int CW = $clog2(WIDTH + 1);

    // r_hi/r_lo hold {partial product, multiplier} or {remainder, dividend->quotient}.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_neg;

    assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_b};
    assign w_neg   = w_trial[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_div  <= is_div;
                r_b    <= b;
                r_busy <= 1'b1;
                r_dz   <= 1'b0;
                if (is_div && (b == '0)) begin
                    r_hi   <= a;
                    r_lo   <= '1;
                    r_dz   <= 1'b1;
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_hi  <= '0;
                    r_lo  <= a;
                    r_cnt <= CW'(WIDTH);
                end
            end else if (r_done) begin
                r_busy <= 1'b0;
            end else if (r_busy) begin
                if (r_div) begin
                    r_hi <= w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], ~w_neg};
                end else begin
                    r_hi <= w_add[WIDTH:1];
                    r_lo <= {w_add[0], r_lo[WIDTH-1:1]};
                end
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign prod_or_qr = {r_hi, r_lo};
    assign dz         = r_dz;

endmodule

// File: rtl/alu_seq_calc.sv
// Button-driven ALU calculator: operand registers, start handshake, single-cycle ops,
// iterative multiply/divide, status flags and an accumulator feedback into A.
module alu_seq_calc
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_a,
    input  logic               btn_b,
    input  logic               btn_go,
    input  logic               acc_mode,
    input  logic [WIDTH-1:0]   in,
    input  logic [2:0]         sel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   a_q,
    output logic [WIDTH-1:0]   b_q,
    output logic               flag_z,
    output logic               flag_c,
    output logic               flag_v,
    output logic               flag_dz
);

    logic [2:0]         r_btn_prev;
    state_t             r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_wa;
    logic [WIDTH-1:0]   r_wb;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_result;
    logic               r_z;
    logic               r_c;
    logic               r_v;
    logic               r_dz;
    logic               r_busy;
    logic               r_done;

    logic               w_edge_a;
    logic               w_edge_b;
    logic               w_edge_go;
    logic               w_start;
    logic               w_md_busy;
    logic               w_md_done;
    logic               w_md_finish;
    logic               w_md_dz;
    logic [2*WIDTH-1:0] w_md_res;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_shl;
    logic [2*WIDTH-1:0] w_exec_res;
    logic               w_exec_c;
    logic               w_exec_v;

    assign w_edge_a  = btn_a  & ~r_btn_prev[0];
    assign w_edge_b  = btn_b  & ~r_btn_prev[1];
    assign w_edge_go = btn_go & ~r_btn_prev[2];

    assign w_start     = (r_state == S_IDLE) && w_edge_go && is_iter_op(sel) && !w_md_busy;
    assign w_md_finish = w_md_done & w_md_busy;

    mul_div_iter #(
        .WIDTH(WIDTH)
    ) u_mul_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .is_div    (sel == OP_DIV),
        .a         (r_a),
        .b         (r_b),
        .busy      (w_md_busy),
        .done      (w_md_done),
        .prod_or_qr(w_md_res),
        .dz        (w_md_dz)
    );

    assign w_sum  = {1'b0, r_wa} + {1'b0, r_wb};
    assign w_diff = {1'b0, r_wa} - {1'b0, r_wb};
    assign w_shl  = {{WIDTH{1'b0}}, r_wa} << r_wb[SHW-1:0];

    always_comb begin
        w_exec_res = '0;
        w_exec_c   = 1'b0;
        w_exec_v   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_exec_res = {{(WIDTH-1){1'b0}}, w_sum};
                w_exec_c   = w_sum[WIDTH];
                w_exec_v   = (r_wa[WIDTH-1] == r_wb[WIDTH-1]) && (w_sum[WIDTH-1] != r_wa[WIDTH-1]);
            end
            OP_SUB: begin
                w_exec_res = {{(WIDTH-1){1'b0}}, w_diff};
                w_exec_c   = w_diff[WIDTH];
                w_exec_v   = (r_wa[WIDTH-1] != r_wb[WIDTH-1]) && (w_diff[WIDTH-1] != r_wa[WIDTH-1]);
            end
            OP_AND:  w_exec_res = {{WIDTH{1'b0}}, r_wa & r_wb};
            OP_OR:   w_exec_res = {{WIDTH{1'b0}}, r_wa | r_wb};
            OP_XOR:  w_exec_res = {{WIDTH{1'b0}}, r_wa ^ r_wb};
            OP_SHL:  w_exec_res = w_shl;
            default: w_exec_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // History starts at 1 so a button held through reset produces no edge.
            r_btn_prev <= '1;
            r_state    <= S_IDLE;
            r_op       <= OP_ADD;
            r_wa       <= '0;
            r_wb       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_z        <= 1'b0;
            r_c        <= 1'b0;
            r_v        <= 1'b0;
            r_dz       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_btn_prev <= {btn_go, btn_b, btn_a};
            case (r_state)
                S_IDLE: begin
                    if (w_edge_a) r_a <= in;
                    if (w_edge_b) r_b <= in;
                    if (w_edge_go) begin
                        // NOTE: non-blocking assignment means the working copies take A/B
                        // as they were before any load in this same cycle.
                        r_op    <= sel;
                        r_wa    <= r_a;
                        r_wb    <= r_b;
                        r_busy  <= 1'b1;
                        r_state <= is_iter_op(sel) ? S_ITER : S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= w_exec_res;
                    r_z      <= (w_exec_res == '0);
                    r_c      <= w_exec_c;
                    r_v      <= w_exec_v;
                    r_dz     <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_ITER: begin
                    if (w_md_finish) begin
                        r_result <= w_md_res;
                        r_z      <= (w_md_res == '0);
                        r_c      <= 1'b0;
                        r_v      <= 1'b0;
                        r_dz     <= w_md_dz;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (acc_mode) r_a <= r_result[WIDTH-1:0];
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign a_q     = r_a;
    assign b_q     = r_b;
    assign flag_z  = r_z;
    assign flag_c  = r_c;
    assign flag_v  = r_v;
    assign flag_dz = r_dz;

endmodule
